// File: rtl/fetch_sequencer.sv
// fetch_sequencer: machine-cycle controller for the 4-bit CPU core.
//   Runs the 8-state microcycle A1 A2 A3 M1 M2 X1 X2 X3 (cycle 0..7), drives
//   the PC nibbles onto the address bus and latches OPR/OPA from ROM. It also
//   issues pc_inc/pc_load/push/pop to the PC/stack unit for JUN, JMS, JCN,
//   ISZ and BBL, and tracks the second word of two-word instructions.
// Optional: define FETCH_SEQ_HALT_EN to add halt_req/halted.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   stall              freeze counter/latches for this clock, mask pulses
//   rom_data[3:0]      ROM nibble (valid cycles 3 and 4)
//   cond_true          jump condition, sampled end of cycle 6 (JCN/ISZ word 1)
//   pc_low/mid/high    current PC nibbles
//   cycle[2:0], sync   microcycle index, sync marker
//   addr_out[3:0]      address bus nibble
//   opr, opa           first-word opcode fields
//   second_word        high during the second-word machine cycle
//   pc_inc, pc_load, jump_addr[11:0], push, pop   PC/stack controls
module fetch_sequencer #(
  parameter int SYNC_CYCLE = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [3:0]  rom_data,
  input  logic        cond_true,
  input  logic [3:0]  pc_low,
  input  logic [3:0]  pc_mid,
  input  logic [3:0]  pc_high,
`ifdef FETCH_SEQ_HALT_EN
  input  logic        halt_req,
  output logic        halted,
`endif
  output logic [2:0]  cycle,
  output logic        sync,
  output logic [3:0]  addr_out,
  output logic [3:0]  opr,
  output logic [3:0]  opa,
  output logic        second_word,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [11:0] jump_addr,
  output logic        push,
  output logic        pop
);

  localparam logic [3:0] OP_JCN = 4'h1;
  localparam logic [3:0] OP_FIM = 4'h2;
  localparam logic [3:0] OP_JUN = 4'h4;
  localparam logic [3:0] OP_JMS = 4'h5;
  localparam logic [3:0] OP_ISZ = 4'h7;
  localparam logic [3:0] OP_BBL = 4'hC;
  localparam logic [2:0] SYNC_IDX = 3'(SYNC_CYCLE);

  logic [2:0] cycle_q, cycle_d;
  logic [3:0] opr_q, opr_d, opa_q, opa_d;
  logic [3:0] w2_hi_q, w2_hi_d, w2_lo_q, w2_lo_d;
  logic       sw_q, sw_d;
  logic       cond_q, cond_d;
  logic       halted_q;
  logic       is_two, is_cond_op, act;

  assign is_two = (opr_q == OP_JCN) || (opr_q == OP_FIM && !opa_q[0]) ||
                  (opr_q == OP_JUN) || (opr_q == OP_JMS) || (opr_q == OP_ISZ);
  assign is_cond_op = (opr_q == OP_JCN) || (opr_q == OP_ISZ);

`ifdef FETCH_SEQ_HALT_EN
  logic halted_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end
  assign halted = halted_q;
`else
  assign halted_q = 1'b0;
`endif

  always_comb begin
    cycle_d = cycle_q;
    opr_d   = opr_q;
    opa_d   = opa_q;
    w2_hi_d = w2_hi_q;
    w2_lo_d = w2_lo_q;
    sw_d    = sw_q;
    cond_d  = cond_q;
`ifdef FETCH_SEQ_HALT_EN
    halted_d = halted_q;
`endif
    if (!stall) begin
      if (halted_q) begin
`ifdef FETCH_SEQ_HALT_EN
        // Parked at cycle 7; resume straight into A1.
        if (!halt_req) begin
          halted_d = 1'b0;
          cycle_d  = 3'd0;
        end
`endif
      end else begin
        cycle_d = cycle_q + 3'd1;
        case (cycle_q)
          3'd3: if (sw_q) w2_hi_d = rom_data; else opr_d = rom_data;
          3'd4: if (sw_q) w2_lo_d = rom_data; else opa_d = rom_data;
          3'd6: if (!sw_q && is_cond_op) cond_d = cond_true;
          3'd7: begin
            sw_d = sw_q ? 1'b0 : is_two;
`ifdef FETCH_SEQ_HALT_EN
            // Never split a two-word instruction: skip halting after word 1.
            if (halt_req && !(!sw_q && is_two)) begin
              halted_d = 1'b1;
              cycle_d  = 3'd7;
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= 3'd0;
      opr_q   <= 4'h0;
      opa_q   <= 4'h0;
      w2_hi_q <= 4'h0;
      w2_lo_q <= 4'h0;
      sw_q    <= 1'b0;
      cond_q  <= 1'b0;
    end else begin
      cycle_q <= cycle_d;
      opr_q   <= opr_d;
      opa_q   <= opa_d;
      w2_hi_q <= w2_hi_d;
      w2_lo_q <= w2_lo_d;
      sw_q    <= sw_d;
      cond_q  <= cond_d;
    end
  end

  // Stall holds the counter at 7, so the action fires on the first
  // non-stalled clock of cycle 7 and the counter then leaves 7: one pulse.
  assign act = (cycle_q == 3'd7) && !stall && !halted_q;

  always_comb begin
    case (cycle_q)
      3'd0:    addr_out = pc_low;
      3'd1:    addr_out = pc_mid;
      3'd2:    addr_out = pc_high;
      default: addr_out = 4'h0;
    endcase
  end

  assign cycle       = cycle_q;
  assign sync        = (cycle_q == SYNC_IDX);
  assign opr         = opr_q;
  assign opa         = opa_q;
  assign second_word = sw_q;
  assign pc_inc      = (cycle_q == 3'd4) && !stall && !halted_q;
  assign pc_load     = act && sw_q && ((opr_q == OP_JUN) || (opr_q == OP_JMS) ||
                                       (is_cond_op && cond_q));
  assign push        = act && sw_q && (opr_q == OP_JMS);
  assign pop         = act && !sw_q && (opr_q == OP_BBL);
  // Conditional jumps stay within the current 256-word page.
  assign jump_addr   = is_cond_op ? {pc_high, w2_hi_q, w2_lo_q}
                                  : {opa_q, w2_hi_q, w2_lo_q};

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Machine-cycle controller for the 4-bit CPU core. It replaces the free-running PC increment with a decoded sequence. It runs the 8-state microcycle (A1 A2 A3 M1 M2 X1 X2 X3) and drives the address nibbles from the PC onto the bus. It latches OPR/OPA from ROM and issues pc_inc, pc_load, push and pop to the PC/stack unit for JUN, JMS, JCN, ISZ and BBL, including two-word instruction tracking.

Parameters:
SYNC_CYCLE, 7, cycle index (0-7) during which sync is asserted; marks the clock before A1.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
stall  in  1  freezes the sequencer for the current clock.
rom_data  in  4  ROM nibble; valid in cycles 3 (M1) and 4 (M2).
cond_true  in  1  JCN/ISZ jump condition from the execute unit; sampled in cycle 6.
pc_low, pc_mid, pc_high  in  4 each  current PC nibbles from the PC/stack unit.
cycle  out  3  current microcycle, 0-7.
sync  out  1  high while cycle == SYNC_CYCLE.
addr_out  out  4  address-bus nibble.
opr, opa  out  4 each  latched opcode fields of the first instruction word.
second_word  out  1  high for the whole machine cycle that fetches a second word.
pc_inc  out  1  one-clock PC increment pulse.
pc_load  out  1  one-clock PC load pulse.
jump_addr  out  12  load value, valid while pc_load is high.
push  out  1  stack push pulse (push occurs before the load in the same clock).
pop  out  1  stack pop pulse.

Behaviour:
- Reset (rst_n low, async): cycle=0, opr=opa=0, second_word=0, jump-address holding registers=0, and every pulse output 0. The first clock after release is A1.
- cycle counter:
  - Advances +1 per clock and wraps 7->0.
  - While stall=1: counter holds, no latch updates, all pulse outputs forced 0.
- addr_out: combinational. pc_low in cycle 0, pc_mid in cycle 1, pc_high in cycle 2, 0 otherwise.
- Latching:
  - First word: at the end of cycle 3, rom_data->opr; at the end of cycle 4, rom_data->opa.
  - Second word: the same two edges latch into internal w2_hi/w2_lo; opr/opa are unchanged.
- pc_inc: high during cycle 4 of every machine cycle (first and second words), exactly 1 clock.
- Two-word decode (evaluated from opr/opa at the end of cycle 7 of a first word): opr=1 JCN; opr=2 with opa[0]=0 FIM; opr=4 JUN; opr=5 JMS; opr=7 ISZ. If two-word, second_word goes 1 at that edge and clears at the end of cycle 7 of the second word.
- cond latch: cond_true is sampled at the end of cycle 6 of a JCN/ISZ first word.
- Cycle-7 actions (all 1-clock pulses), JUN/JMS/JCN/ISZ in the second word, BBL in its single word:
  - JUN: pc_load=1, jump_addr={opa, w2_hi, w2_lo}.
  - JMS: push=1 and pc_load=1 in the same clock, jump_addr as JUN.
  - JCN/ISZ: pc_load=1 only if the latched cond=1; jump_addr={pc_high, w2_hi, w2_lo}.
  - FIM: no PC action.
  - BBL (opr=0xC, single word): pop=1.
  - All other opcodes: no PC action.
- push, pop and pc_load never coincide with pc_inc.
- Stall in cycle 7 delays the action pulse until the first non-stalled clock of cycle 7. The pulse is issued once only.
- Reset mid-instruction aborts it. second_word clears, and no pending load fires after reset.

Optional Feature:
FETCH_SEQ_HALT_EN.
- With it defined:
  - Adds input halt_req and output halted.
  - When halt_req=1 at the end of cycle 7, the counter holds at 7, halted=1, and no pulses are issued.
  - Resumes to cycle 0 on the first clock with halt_req=0; halted clears at that same edge.
  - A halt request during a two-word instruction is honoured only after its second word completes.
- Without it: no extra ports; behaviour as above.

Test Plan:
1. Release reset, rom_data feeds NOP (0,0) -> cycle 0..7 repeats; pc_inc high exactly in cycle 4; sync high in cycle 7; addr_out = pc_low/mid/high in cycles 0/1/2.
2. JUN: words 0x4,0x3 then 0xA,0x5 -> second_word=1 for the 2nd machine cycle; pc_load pulse in its cycle 7 with jump_addr=0x3A5; no push.
3. JMS 0x5,0x1 / 0x2,0x3 -> push and pc_load both high in the same cycle-7 clock; jump_addr=0x123. Then BBL 0xC,0x0 -> pop in cycle 7 only.
4. JCN 0x1,0x4 / 0x7,0x8 with pc_high=0x2:
   - cond_true=1 in cycle 6 -> pc_load, jump_addr=0x278.
   - Repeat with cond_true=0 -> no pc_load; pc_inc pulses unchanged.
5. Stall held 3 clocks during cycle 7 of JUN -> cycle stays 7; pc_load fires once after stall drops; counter then wraps to 0.
6. rst_n low during cycle 5 of the JUN second word -> all outputs 0 immediately; no pc_load after release; next word decoded as a first word.
